// File: rtl/smem_result_writer.sv
// smem_result_writer
//   Packs SMEM results (128-bit entries, four per 512-bit line) into cache
//   lines, queues the lines in a small FIFO and streams them to the host with
//   a valid/ready handshake.
//   It stalls the pipeline when the FIFO is nearly full or when the block is
//   not collecting. It counts completed reads, flushes the final partial line
//   at the end of a batch and raises batch_done once the FIFO has drained.
//
//   Optional feature: define SMEM_RESULT_TRAILER_EN to append one trailer
//   line per batch. The trailer carries the result, line and read counts.
//
// Ports:
//   clk, reset              clock, async active-high reset
//   start, batch_size       arm a new batch (batch_size sampled on start)
//   result_*                incoming SMEM result fields
//   read_done               one read fully processed
//   stall                   pipeline hold
//   out_valid/out_data/out_ready  line stream to host
//   result_count, line_count      per-batch counters
//   batch_done              batch written and FIFO drained
module smem_result_writer #(
    parameter int CL              = 512,
    parameter int READ_NUM_WIDTH  = 6,
    parameter int LINE_FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [READ_NUM_WIDTH:0]   batch_size,
    input  logic                      result_valid,
    input  logic [READ_NUM_WIDTH-1:0] result_read_num,
    input  logic [32:0]               result_x0,
    input  logic [32:0]               result_x1,
    input  logic [32:0]               result_x2,
    input  logic [6:0]                result_start,
    input  logic [6:0]                result_end,
    input  logic                      read_done,
    output logic                      stall,
    output logic                      out_valid,
    output logic [CL-1:0]             out_data,
    input  logic                      out_ready,
    output logic [15:0]               result_count,
    output logic [15:0]               line_count,
    output logic                      batch_done
);

    localparam int PW = $clog2(LINE_FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, COLLECT, FLUSH, TRAIL, DONE} state_t;

    state_t                   state, state_nxt;
    logic [CL-1:0]            mem [LINE_FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            fifo_count, fifo_count_nxt;
    logic [3:0][127:0]        pack;        // slot 3 is never stored; line completes on that accept
    logic [1:0]               slot;
    logic [READ_NUM_WIDTH:0]  batch_len;
    logic [READ_NUM_WIDTH:0]  reads_done;
    logic [127:0]             entry;
    logic [CL-1:0]            push_data;
    logic                     accept, rd_cnt, push, pop, data_line, full;

    always_comb begin
        entry = {1'b1, 8'd0, 6'(result_read_num), result_end, result_start,
                 result_x2, result_x1, result_x0};
        full  = (fifo_count == CW'(LINE_FIFO_DEPTH));
        // Threshold of DEPTH-1 leaves room for the line completed by the
        // accept that sees stall low, so a push never meets a full FIFO.
        stall = !reset && ((fifo_count >= CW'(LINE_FIFO_DEPTH - 1)) || (state != COLLECT));
        accept = (state == COLLECT) && result_valid && !stall;
        rd_cnt = (state == COLLECT) && read_done && !stall;
        pop    = out_valid && out_ready;

        push      = 1'b0;
        data_line = 1'b0;
        push_data = '0;
        state_nxt = state;

        case (state)
            IDLE, DONE: begin
                if (start)
                    state_nxt = (batch_size == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                if (accept && slot == 2'd3) begin
                    push      = 1'b1;
                    data_line = 1'b1;
                    push_data = {entry, pack[2], pack[1], pack[0]};
                end
                // Registered count: transition lands the cycle after the last read_done.
                if (reads_done >= batch_len)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (slot == 2'd0) begin
                    state_nxt = TRAIL;
                end else if (!full) begin
                    // Unused slots are already zero, so their valid bits are 0.
                    push      = 1'b1;
                    data_line = 1'b1;
                    push_data = pack;
                    state_nxt = TRAIL;
                end
            end
            TRAIL: begin
`ifdef SMEM_RESULT_TRAILER_EN
                if (!full) begin
                    push                  = 1'b1;
                    push_data[15:0]       = result_count;
                    push_data[31:16]      = line_count;
                    push_data[38:32]      = 7'(reads_done);
                    push_data[CL-1]       = 1'b1;
                    state_nxt             = DONE;
                end
`else
                state_nxt = DONE;
`endif
            end
            default: state_nxt = IDLE;
        endcase

        case ({push, pop})
            2'b10:   fifo_count_nxt = fifo_count + CW'(1);
            2'b01:   fifo_count_nxt = fifo_count - CW'(1);
            default: fifo_count_nxt = fifo_count;
        endcase
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Line storage carries no reset; visibility is gated by fifo_count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            pack         <= '0;
            slot         <= '0;
            batch_len    <= '0;
            reads_done   <= '0;
            result_count <= '0;
            line_count   <= '0;
            batch_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            fifo_count <= fifo_count_nxt;
            batch_done <= (state_nxt == DONE) && (fifo_count_nxt == '0);

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            if (data_line && line_count != 16'hFFFF)
                line_count <= line_count + 16'd1;

            if (accept) begin
                if (result_count != 16'hFFFF)
                    result_count <= result_count + 16'd1;
                if (slot == 2'd3)
                    pack <= '0;
                else
                    pack[slot] <= entry;
                slot <= slot + 2'd1;
            end

            if (rd_cnt && reads_done != '1)
                reads_done <= reads_done + 1'b1;

            if (state == FLUSH && push) begin
                pack <= '0;
                slot <= '0;
            end

            if ((state == IDLE || state == DONE) && start) begin
                batch_len    <= batch_size;
                reads_done   <= '0;
                result_count <= '0;
                line_count   <= '0;
                pack         <= '0;
                slot         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_smem_result_writer.sv
// Directed testbench for smem_result_writer: one task per scenario, inline
// checks against hand-derived expectations, summary line at the end.
module tb_smem_result_writer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [6:0]   batch_size;
    logic         result_valid;
    logic [5:0]   result_read_num;
    logic [32:0]  result_x0, result_x1, result_x2;
    logic [6:0]   result_start, result_end;
    logic         read_done;
    logic         stall;
    logic         out_valid;
    logic [511:0] out_data;
    logic         out_ready;
    logic [15:0]  result_count, line_count;
    logic         batch_done;

    int n_chk  = 0;
    int n_fail = 0;
    logic [511:0] lines[$];

    smem_result_writer dut (
        .clk(clk), .reset(reset), .start(start), .batch_size(batch_size),
        .result_valid(result_valid), .result_read_num(result_read_num),
        .result_x0(result_x0), .result_x1(result_x1), .result_x2(result_x2),
        .result_start(result_start), .result_end(result_end),
        .read_done(read_done), .stall(stall), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready),
        .result_count(result_count), .line_count(line_count),
        .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    // Record every line the host consumes.
    always @(posedge clk)
        if (!reset && out_valid && out_ready)
            lines.push_back(out_data);

    // Expected 128-bit entry for a result generated from seed x.
    function automatic logic [127:0] ent(input int x, input int rn);
        logic [127:0] e;
        e = {1'b1, 8'd0, 6'(rn), 7'(x + 1), 7'(x), 33'(x + 200), 33'(x + 100), 33'(x)};
        return e;
    endfunction

    function automatic logic [511:0] line4(input int b, input int rn);
        return {ent(b + 3, rn), ent(b + 2, rn), ent(b + 1, rn), ent(b, rn)};
    endfunction

    task automatic set_result(input int x, input int rn);
        result_x0       = 33'(x);
        result_x1       = 33'(x + 100);
        result_x2       = 33'(x + 200);
        result_start    = 7'(x);
        result_end      = 7'(x + 1);
        result_read_num = 6'(rn);
    endtask

    // Called at a negedge; waits for stall low, presents for one cycle.
    task automatic send(input int x, input int rn, input bit rv, input bit rd);
        int n = 0;
        while (stall && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            n_fail++;
            $display("FAIL send_timeout: stall still %0b after %0d cycles, want 0", stall, n);
        end
        set_result(x, rn);
        result_valid = rv;
        read_done    = rd;
        @(negedge clk);
        result_valid = 1'b0;
        read_done    = 1'b0;
    endtask

    task automatic start_batch(input int bs);
        start      = 1'b1;
        batch_size = 7'(bs);
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!batch_done && n < 100) begin @(negedge clk); n++; end
        n_chk++;
        if (batch_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done: batch_done=%0b after %0d cycles, want 1", batch_done, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; batch_size = '0; result_valid = 1'b0;
        read_done = 1'b0; set_result(0, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        lines.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; batch_size = '0; result_valid = 1'b0;
        read_done = 1'b0; out_ready = 1'b1; set_result(0, 0);
        #1;
        n_chk++;
        if ({stall, out_valid, batch_done, result_count, line_count} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got st=%0b ov=%0b bd=%0b rc=%0d lc=%0d, want all 0",
                     stall, out_valid, batch_done, result_count, line_count);
        end
        n_chk++;
        if (out_data !== 512'd0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h, want 0", out_data);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_stall: got %0b, want 1", stall);
        end
    endtask

    task automatic test_happy();
        do_reset();
        out_ready = 1'b1;
        start_batch(2);
        send(1, 0, 1, 0); send(2, 0, 1, 0); send(3, 0, 1, 0);
        send(0, 0, 0, 1);
        send(4, 1, 1, 0);
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== {ent(4, 1), ent(3, 0), ent(2, 0), ent(1, 0)}) begin
            n_fail++;
            $display("FAIL happy_latency: ov=%0b data=%h", out_valid, out_data);
        end
        send(5, 1, 1, 0);
        send(0, 0, 0, 1);
        wait_done();
        @(negedge clk);
        n_chk++;
        if (result_count !== 16'd5 || line_count !== 16'd2) begin
            n_fail++;
            $display("FAIL happy_counts: rc=%0d lc=%0d, want 5 2", result_count, line_count);
        end
`ifdef SMEM_RESULT_TRAILER_EN
        n_chk++;
        if (lines.size() !== 3) begin
            n_fail++;
            $display("FAIL happy_nlines: got %0d, want 3", lines.size());
        end else begin
            n_chk++;
            if (lines[2][38:0] !== {7'd2, 16'd2, 16'd5} || lines[2][511] !== 1'b1) begin
                n_fail++;
                $display("FAIL happy_trailer: got %h", lines[2]);
            end
        end
`else
        n_chk++;
        if (lines.size() !== 2) begin
            n_fail++;
            $display("FAIL happy_nlines: got %0d, want 2", lines.size());
        end
`endif
        if (lines.size() >= 2) begin
            n_chk++;
            if (lines[0] !== {ent(4, 1), ent(3, 0), ent(2, 0), ent(1, 0)}) begin
                n_fail++;
                $display("FAIL happy_line0: got %h", lines[0]);
            end
            n_chk++;
            if (lines[1] !== {384'd0, ent(5, 1)}) begin
                n_fail++;
                $display("FAIL happy_line1: got %h", lines[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        start_batch(1);
        for (int i = 0; i < 12; i++) send(10 + i, 3, 1, 0);
        n_chk++;
        if (stall !== 1'b1 || line_count !== 16'd3 || result_count !== 16'd12) begin
            n_fail++;
            $display("FAIL bp_stall: st=%0b lc=%0d rc=%0d, want 1 3 12", stall, line_count, result_count);
        end
        // Hold a result while stalled: it must not be taken.
        set_result(22, 3);
        result_valid = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        result_valid = 1'b0;
        n_chk++;
        if (result_count !== 16'd12) begin
            n_fail++;
            $display("FAIL bp_hold: rc=%0d, want 12", result_count);
        end
        out_ready = 1'b1;
        for (int i = 12; i < 16; i++) send(10 + i, 3, 1, 0);
        send(0, 0, 0, 1);
        wait_done();
        n_chk++;
        if (result_count !== 16'd16 || line_count !== 16'd4) begin
            n_fail++;
            $display("FAIL bp_counts: rc=%0d lc=%0d, want 16 4", result_count, line_count);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (lines.size() <= k || lines[k] !== line4(10 + 4 * k, 3)) begin
                n_fail++;
                $display("FAIL bp_line%0d: got %h", k, (lines.size() > k) ? lines[k] : 512'd0);
            end
        end
    endtask

    task automatic test_exact_multiple();
        do_reset();
        out_ready = 1'b1;
        start_batch(1);
        for (int i = 0; i < 8; i++) send(60 + i, 5, 1, 0);
        send(0, 0, 0, 1);
        wait_done();
        n_chk++;
        if (line_count !== 16'd2 || result_count !== 16'd8) begin
            n_fail++;
            $display("FAIL exact_counts: lc=%0d rc=%0d, want 2 8", line_count, result_count);
        end
`ifndef SMEM_RESULT_TRAILER_EN
        n_chk++;
        if (lines.size() !== 2) begin
            n_fail++;
            $display("FAIL exact_nlines: got %0d, want 2", lines.size());
        end
`endif
        n_chk++;
        if (lines.size() < 2 || lines[1] !== line4(64, 5)) begin
            n_fail++;
            $display("FAIL exact_line1: got %h", (lines.size() > 1) ? lines[1] : 512'd0);
        end
    endtask

    task automatic test_zero_batch();
        do_reset();
        out_ready = 1'b1;
        n_chk++;
        if (batch_done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_pre: batch_done=%0b, want 0", batch_done);
        end
        start_batch(0);
        n_chk++;
        if (batch_done !== 1'b1 || out_valid !== 1'b0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: bd=%0b ov=%0b st=%0b, want 1 0 1", batch_done, out_valid, stall);
        end
        @(negedge clk); @(negedge clk);
        n_chk++;
        if (lines.size() !== 0 || line_count !== 16'd0) begin
            n_fail++;
            $display("FAIL zero_lines: got %0d lines lc=%0d, want 0 0", lines.size(), line_count);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        out_ready = 1'b1;
        start_batch(1);
        send(30, 2, 1, 0); send(31, 2, 1, 0);
        send(32, 2, 1, 1);
        wait_done();
        n_chk++;
        if (result_count !== 16'd3 || line_count !== 16'd1) begin
            n_fail++;
            $display("FAIL same_counts: rc=%0d lc=%0d, want 3 1", result_count, line_count);
        end
        n_chk++;
        if (lines.size() < 1 || lines[0] !== {256'd0, ent(32, 2), ent(31, 2), ent(30, 2)}) begin
            n_fail++;
            $display("FAIL same_line: got %h", (lines.size() > 0) ? lines[0] : 512'd0);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        start_batch(1);
        for (int i = 0; i < 9; i++) send(40 + i, 7, 1, 0);
        n_chk++;
        if (out_valid !== 1'b1 || result_count !== 16'd9 || line_count !== 16'd2) begin
            n_fail++;
            $display("FAIL mid_pre: ov=%0b rc=%0d lc=%0d, want 1 9 2", out_valid, result_count, line_count);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if ({out_valid, stall, result_count, line_count, batch_done} !== 35'd0 || out_data !== 512'd0) begin
            n_fail++;
            $display("FAIL mid_async: ov=%0b st=%0b rc=%0d lc=%0d, want all 0",
                     out_valid, stall, result_count, line_count);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); @(negedge clk);
        n_chk++;
        if (stall !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_idle: st=%0b ov=%0b, want 1 0", stall, out_valid);
        end
        out_ready = 1'b1;
        start_batch(1);
        send(0, 0, 0, 1);
        wait_done();
        n_chk++;
        if (line_count !== 16'd0 || result_count !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_discard_counts: lc=%0d rc=%0d, want 0 0", line_count, result_count);
        end
`ifndef SMEM_RESULT_TRAILER_EN
        n_chk++;
        if (lines.size() !== 0) begin
            n_fail++;
            $display("FAIL mid_discard_lines: got %0d, want 0", lines.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_happy();
        test_backpressure();
        test_exact_multiple();
        test_zero_batch();
        test_same_cycle();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
